// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  // Number of bytes in the little-endian length prefix
  localparam int LEN_BYTES = 4;

  // Width of the running image checksum (sum of bytes mod 256)
  localparam int SUM_WIDTH = 8;

  // Loader sequencing states; ST_CHK is only reachable with the checksum build
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Load stream, CPU fetch and memory port signals of the loader.
//            slave  = the loader itself, master = its environment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8
);

  logic                     start;
  logic                     rx_valid;
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_ready;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     cpu_hold;
  logic                     done;
  logic                     error;

  modport slave (
    input  start, rx_valid, rx_data, pc,
    output rx_ready, mem_addr, mem_we, mem_wdata, cpu_hold, done, error
  );

  modport master (
    output start, rx_valid, rx_data, pc,
    input  rx_ready, mem_addr, mem_we, mem_wdata, cpu_hold, done, error
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader_le_word_assembler.sv
// ============================================================================
// Module   : le_word_assembler
// Purpose  : Collects NUM_BYTES bytes, first byte least significant, into one
//            word. o_word_next/o_word_done expose the completed word in the
//            same cycle as the final byte so the caller can act without a
//            bubble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module le_word_assembler #(
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = 4
) (
  input  wire logic                            clk,
  input  wire logic                            rst_n,
  input  wire logic                            i_clear,
  input  wire logic                            i_push,
  input  wire logic [BYTE_WIDTH-1:0]           i_byte,
  output logic      [BYTE_WIDTH*NUM_BYTES-1:0] o_word,
  output logic      [BYTE_WIDTH*NUM_BYTES-1:0] o_word_next,
  output logic                                 o_word_done
);

  localparam int WORD_W = BYTE_WIDTH * NUM_BYTES;
  localparam int CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_count;

  // New bytes enter at the top and shift down, so the first byte ends up at bit 0
  assign o_word_next = {i_byte, r_word[WORD_W-1:BYTE_WIDTH]};
  assign o_word_done = i_push && (r_count == CNT_W'(NUM_BYTES - 1));
  assign o_word      = r_word;

  // Shift register and byte counter; counter rewinds after a full word
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_word  <= o_word_next;
      r_count <= o_word_done ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot loader for the byte-addressed instruction memory. Takes a
//            4-byte little-endian length followed by the image bytes on a
//            valid/ready stream, writes them one per cycle while stalling the
//            CPU, then gives the memory address port to the CPU PC.
// Options  : IMEM_LOADER_CHECKSUM_EN - append a one-byte checksum (sum of
//            image bytes mod 256) that must match before RUN is entered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_DEPTH     = 256
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  imem_loader_if.slave bus
);

  localparam int LEN_W = LEN_BYTES * DATA_WIDTH;
  // One extra bit so the pointer can reach MEM_DEPTH after the last write
  localparam int PTR_W = $clog2(MEM_DEPTH + 1);

  loader_state_t    r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic             r_done;
  logic             r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [SUM_WIDTH-1:0] r_sum;
`endif

  logic             w_accept;
  logic             w_len_clear;
  logic             w_len_push;
  logic             w_len_done;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_len_next;
  logic             w_last;

  // The length register is cleared whenever a (re)load is granted
  assign w_len_clear = bus.start && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_len_push  = (r_state == ST_LEN) && bus.rx_valid;

  le_word_assembler #(
    .BYTE_WIDTH (DATA_WIDTH),
    .NUM_BYTES  (LEN_BYTES)
  ) u_len (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_len_clear),
    .i_push      (w_len_push),
    .i_byte      (bus.rx_data),
    .o_word      (w_len),
    .o_word_next (w_len_next),
    .o_word_done (w_len_done)
  );

  assign bus.rx_ready  = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_accept      = bus.rx_valid && bus.rx_ready;
  assign bus.mem_we    = (r_state == ST_DATA) && bus.rx_valid;
  assign bus.mem_wdata = bus.rx_data;
  assign bus.mem_addr  = (r_state == ST_RUN) ? bus.pc : ADDRESS_WIDTH'(r_wr_ptr);
  assign bus.cpu_hold  = (r_state != ST_RUN);
  assign bus.done      = r_done;
  assign bus.error     = r_error;

  // DATA is only entered with len >= 1, so len-1 never underflows there
  assign w_last = (LEN_W'(r_wr_ptr) == (w_len - LEN_W'(1)));

  // Load sequencer: length, data, optional checksum, then hand-off to the CPU
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state  <= ST_LEN;
            r_error  <= 1'b0;
            r_wr_ptr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end

        ST_LEN: begin
          if (w_accept && w_len_done) begin
            if (w_len_next == '0) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
            end else if (w_len_next > LEN_W'(MEM_DEPTH)) begin
              r_state <= ST_IDLE;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum    <= r_sum + SUM_WIDTH'(bus.rx_data);
            if (w_last) begin
              r_state <= ST_CHK;
            end
`else
            if (w_last) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
            end
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_accept) begin
            if (SUM_WIDTH'(bus.rx_data) == r_sum) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_error <= 1'b1;
            end
          end
        end
`endif

        ST_RUN: begin
          if (bus.start) begin
            r_state  <= ST_LEN;
            r_error  <= 1'b0;
            r_wr_ptr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Builds IMEM_LOADER_CHECKSUM_EN
//            aware images, models the instruction memory and counts writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) bus ();

  imem_loader #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory model plus event counters
  logic [7:0] tb_mem [0:DEPTH-1];
  int         wr_count   = 0;
  int         done_count = 0;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (bus.done) done_count <= done_count + 1;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] img [0:DEPTH-1];

  typedef struct {
    logic [31:0] len;
    bit          exp_err;
  } len_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; waits a bounded time for acceptance
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    bit ok;
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.start    = with_start;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus.rx_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=%0d expected=%0d", 0, 1);
    end
  endtask

  // Full load of img[0..len-1] with the expected outcome derived from the rules
  task automatic run_load(input logic [31:0] len, input bit exp_len_err, input bit bad_ck,
                          input int gmin, input int gmax, input bit start_last);
    int         w0, d0, bad;
    logic [7:0] s, ck;
    bit         exp_err;
    w0 = wr_count;
    d0 = done_count;
    pulse_start();
    check("start_hold", 32'(bus.cpu_hold), 1);
    check("start_ready", 32'(bus.rx_ready), 1);
    check("start_clears_error", 32'(bus.error), 0);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], $urandom_range(gmin, gmax), 1'b0);
    if (exp_len_err) begin
      check("len_error", 32'(bus.error), 1);
      check("len_err_hold", 32'(bus.cpu_hold), 1);
      check("len_err_ready", 32'(bus.rx_ready), 0);
      check("len_err_writes", 32'(wr_count - w0), 0);
      check("len_err_done", 32'(done_count - d0), 0);
    end else begin
      s = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
        s = s + img[i];
        send_byte(img[i], $urandom_range(gmin, gmax), start_last && !CK && (i == int'(len) - 1));
      end
      exp_err = CK && bad_ck && (len != 0);
      if (CK && len != 0) begin
        ck = bad_ck ? ((s == 8'h00) ? 8'h01 : 8'h00) : s;
        send_byte(ck, $urandom_range(gmin, gmax), start_last);
      end
      check("data_writes", 32'(wr_count - w0), len);
      bad = 0;
      for (int i = 0; i < int'(len); i++) if (tb_mem[i] !== img[i]) bad++;
      check("mem_contents", 32'(bad), 0);
      if (exp_err) begin
        check("ck_error", 32'(bus.error), 1);
        check("ck_err_hold", 32'(bus.cpu_hold), 1);
        check("ck_err_ready", 32'(bus.rx_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        check("ck_err_hold_stays", 32'(bus.cpu_hold), 1);
        check("ck_err_no_done", 32'(done_count - d0), 0);
      end else begin
        check("done_first_run", 32'(bus.done), 1);
        check("run_hold_low", 32'(bus.cpu_hold), 0);
        check("run_no_error", 32'(bus.error), 0);
        for (int p = 0; p < 12; p += 4) begin
          bus.pc = 32'(p);
          #1;
          check("run_mem_addr_pc", bus.mem_addr, 32'(p));
          check("run_no_we", 32'(bus.mem_we), 0);
        end
        @(posedge clk); #1;
        check("done_single_pulse", 32'(bus.done), 0);
        check("run_hold_stays_low", 32'(bus.cpu_hold), 0);
        check("done_count", 32'(done_count - d0), 1);
      end
    end
  endtask

  len_vec_t vecs [8];

  initial begin
    int          w0, r;
    logic [31:0] len;
    bit          bad_ck;

    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.pc       = 32'h0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, no start: stray stream traffic must be ignored
    w0 = wr_count;
    for (int c = 0; c < 8; c++) begin
      check("idle_status", {27'd0, bus.cpu_hold, bus.rx_ready, bus.mem_we, bus.error, bus.done},
            32'b10000);
      check("idle_mem_addr", bus.mem_addr, 0);
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    check("idle_no_writes", 32'(wr_count - w0), 0);

    // Reference image 13 05 A0 00 (checksum B8 when enabled)
    img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'hA0; img[3] = 8'h00;
    run_load(32'd4, 1'b0, 1'b0, 0, 0, 1'b0);

    // Length table: boundaries around MEM_DEPTH and huge values
    vecs[0] = '{32'd0,          1'b0};
    vecs[1] = '{32'd1,          1'b0};
    vecs[2] = '{32'd3,          1'b0};
    vecs[3] = '{32'd256,        1'b0};
    vecs[4] = '{32'd257,        1'b1};
    vecs[5] = '{32'h0000_0201,  1'b1};
    vecs[6] = '{32'h0100_0000,  1'b1};
    vecs[7] = '{32'hFFFF_FFFF,  1'b1};
    foreach (vecs[v]) begin
      for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
      run_load(vecs[v].len, vecs[v].exp_err, 1'b0, 0, 1, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum on 11 22, then a good load must clear the error
    img[0] = 8'h11; img[1] = 8'h22;
    run_load(32'd2, 1'b0, 1'b1, 0, 0, 1'b0);
    run_load(32'd2, 1'b0, 1'b0, 0, 0, 1'b0);
`endif

    // Reset in the middle of a 4-byte image, then a 1-byte reload
    w0 = wr_count;
    pulse_start();
    send_byte(8'h04, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0); send_byte(8'hBB, 0, 1'b0);
    check("midload_writes", 32'(wr_count - w0), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_hold", 32'(bus.cpu_hold), 1);
    check("midreset_ready", 32'(bus.rx_ready), 0);
    check("midreset_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    img[0] = tb_mem[0] ^ 8'h5A;
    run_load(32'd1, 1'b0, 1'b0, 0, 0, 1'b0);

    // Start in RUN reloads; 3-cycle gaps between bytes
    for (int i = 0; i < 6; i++) img[i] = 8'($urandom);
    run_load(32'd6, 1'b0, 1'b0, 3, 3, 1'b0);

    // Start coinciding with the final byte is ignored
    for (int i = 0; i < 3; i++) img[i] = 8'($urandom);
    run_load(32'd3, 1'b0, 1'b0, 0, 0, 1'b1);

    // Randomized images; the outcome follows from the length rule
    for (int t = 0; t < 10; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       len = 32'($urandom_range(1, 40));
      else if (r == 7) len = 32'($urandom_range(257, 400));
      else if (r == 8) len = 32'd0;
      else             len = 32'd256;
      bad_ck = CK && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
      run_load(len, len > 32'(DEPTH), bad_ck, 0, 3, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if something stalls beyond any legitimate run length
  initial begin
    #600000;
    $display("FAIL watchdog actual=%0d expected=%0d", 1, 0);
    $fatal(1);
  end

endmodule

`default_nettype wire
